// File: rtl/fix_field_extractor.sv
// FIX tag=value field splitter: parses an SOH-delimited byte stream into
// per-field records and verifies the tag-10 checksum against the running sum.
module fix_field_extractor #(
    parameter int         TAG_DIGITS = 5,
    parameter int         VAL_BYTES  = 32,
    parameter logic [7:0] SOH        = 8'h01
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [7:0]                     in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_tag,
    output logic [8*VAL_BYTES-1:0]         out_value,
    output logic [$clog2(VAL_BYTES+1)-1:0] out_len,
    output logic                           out_first,
    output logic                           out_last,
    output logic                           out_cksum_ok,
    output logic                           out_err
);

    localparam int LW = $clog2(VAL_BYTES + 1);
    localparam int DW = $clog2(TAG_DIGITS + 1);
    localparam int VW = 8 * VAL_BYTES;

    typedef enum logic [1:0] {
        S_TAG,
        S_VALUE,
        S_SKIP
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   tag_q, tag_d;
    logic [DW-1:0] dig_q, dig_d;
    logic [VW-1:0] val_q, val_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    fsum_q, fsum_d;
    logic [7:0]    run_q, run_d;

    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_tag_q, out_tag_d;
    logic [VW-1:0] out_value_q, out_value_d;
    logic [LW-1:0] out_len_q, out_len_d;
    logic          out_first_q, out_first_d;
    logic          out_last_q, out_last_d;
    logic          out_ok_q, out_ok_d;
    logic          out_err_q, out_err_d;

    logic accept;
    logic is_soh;
    logic is_eq;
    logic is_digit;
    logic emit;

    assign in_ready = !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign is_soh   = (in_data == SOH);
    assign is_eq    = (in_data == 8'h3D);
    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign emit     = accept && is_soh;

    // Record classification for the field currently being closed
    logic          rec_err;
    logic          rec_first;
    logic          rec_last;
    logic          rec_ok;
    logic [VW+23:0] val_ext;
    logic [7:0]    b2, b1, b0;
    logic          all_dig;
    logic [9:0]    dec;

    assign val_ext   = {24'd0, val_q};
    assign b2        = val_ext[23:16];
    assign b1        = val_ext[15:8];
    assign b0        = val_ext[7:0];
    assign all_dig   = (b2 >= 8'h30) && (b2 <= 8'h39)
                    && (b1 >= 8'h30) && (b1 <= 8'h39)
                    && (b0 >= 8'h30) && (b0 <= 8'h39);
    assign dec       = 10'(b2[3:0]) * 10'd100
                     + 10'(b1[3:0]) * 10'd10
                     + 10'(b0[3:0]);
    assign rec_err   = (state_q != S_VALUE);
    assign rec_first = !rec_err && (tag_q == 32'd8);
    assign rec_last  = !rec_err && (tag_q == 32'd10);
    assign rec_ok    = rec_last && (len_q == LW'(3)) && all_dig
                    && (dec == {2'b00, run_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_TAG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                S_TAG: begin
                    if (is_soh) begin
                        state_d = S_TAG;
                    end else if (is_eq) begin
                        state_d = (dig_q == '0) ? S_SKIP : S_VALUE;
                    end else if (is_digit && dig_q != DW'(TAG_DIGITS)) begin
                        state_d = S_TAG;
                    end else begin
                        state_d = S_SKIP;
                    end
                end
                S_VALUE: begin
                    if (is_soh) begin
                        state_d = S_TAG;
                    end else if (len_q == LW'(VAL_BYTES)) begin
                        state_d = S_SKIP;
                    end
                end
                S_SKIP: begin
                    if (is_soh) begin
                        state_d = S_TAG;
                    end
                end
                default: state_d = S_TAG;
            endcase
        end
    end

    always_comb begin
        tag_d       = tag_q;
        dig_d       = dig_q;
        val_d       = val_q;
        len_d       = len_q;
        fsum_d      = fsum_q;
        run_d       = run_q;
        out_valid_d = out_valid_q && !out_ready;
        out_tag_d   = out_tag_q;
        out_value_d = out_value_q;
        out_len_d   = out_len_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_ok_d    = out_ok_q;
        out_err_d   = out_err_q;
        if (accept) begin
            fsum_d = fsum_q + in_data;
        end
        if (emit) begin
            out_valid_d = 1'b1;
            out_tag_d   = tag_q;
            out_value_d = val_q;
            out_len_d   = len_q;
            out_first_d = rec_first;
            out_last_d  = rec_last;
            out_ok_d    = rec_ok;
            out_err_d   = rec_err;
            tag_d       = '0;
            dig_d       = '0;
            val_d       = '0;
            len_d       = '0;
            fsum_d      = '0;
            // A tag-8 field restarts the sum with its own bytes and SOH
            run_d = (rec_first ? 8'd0 : run_q) + fsum_q + in_data;
        end else if (accept && state_q == S_TAG && is_digit
                     && dig_q != DW'(TAG_DIGITS)) begin
            tag_d = tag_q * 32'd10 + 32'(in_data[3:0]);
            dig_d = dig_q + DW'(1);
        end else if (accept && state_q == S_VALUE
                     && len_q != LW'(VAL_BYTES)) begin
            val_d = (val_q << 8) | VW'(in_data);
            len_d = len_q + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= '0;
            dig_q       <= '0;
            val_q       <= '0;
            len_q       <= '0;
            fsum_q      <= '0;
            run_q       <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_value_q <= '0;
            out_len_q   <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ok_q    <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            dig_q       <= dig_d;
            val_q       <= val_d;
            len_q       <= len_d;
            fsum_q      <= fsum_d;
            run_q       <= run_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_value_q <= out_value_d;
            out_len_q   <= out_len_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_ok_q    <= out_ok_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_tag      = out_tag_q;
    assign out_value    = out_value_q;
    assign out_len      = out_len_q;
    assign out_first    = out_first_q;
    assign out_last     = out_last_q;
    assign out_cksum_ok = out_ok_q;
    assign out_err      = out_err_q;

endmodule

// File: tb/tb_fix_field_extractor.sv
// Directed bench for fix_field_extractor: default instance plus a
// VAL_BYTES=4 instance for value-overflow cases.
module tb_fix_field_extractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] in_data = 8'h00;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_tag;
    logic [255:0] out_value;
    logic [5:0]   out_len;
    logic         out_first, out_last, out_cksum_ok, out_err;

    logic         in_valid_b = 1'b0;
    logic         in_ready_b;
    logic         out_valid_b;
    logic         out_ready_b = 1'b1;
    logic [31:0]  out_tag_b;
    logic [31:0]  out_value_b;
    logic [2:0]   out_len_b;
    logic         out_first_b, out_last_b, out_cksum_ok_b, out_err_b;

    always #5 clk = ~clk;

    fix_field_extractor dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_value(out_value), .out_len(out_len),
        .out_first(out_first), .out_last(out_last),
        .out_cksum_ok(out_cksum_ok), .out_err(out_err)
    );

    fix_field_extractor #(.VAL_BYTES(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_data(in_data), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_tag(out_tag_b), .out_value(out_value_b), .out_len(out_len_b),
        .out_first(out_first_b), .out_last(out_last_b),
        .out_cksum_ok(out_cksum_ok_b), .out_err(out_err_b)
    );

    typedef struct {
        string        s;
        logic [31:0]  tag;
        logic [255:0] val;
        int           len;
        bit           err;
        bit           first;
        bit           last;
        bit           ok;
    } vec_t;

    typedef struct {
        logic [31:0]  tag;
        logic [255:0] val;
        int           len;
        bit           err;
        bit           first;
        bit           last;
        bit           ok;
    } rec_t;

    rec_t qa[$];
    rec_t qb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Capture each consumed record mid-low-phase
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready)
            qa.push_back('{out_tag, out_value, int'(out_len), out_err,
                           out_first, out_last, out_cksum_ok});
        if (!rst && out_valid_b && out_ready_b)
            qb.push_back('{out_tag_b, 256'(out_value_b), int'(out_len_b),
                           out_err_b, out_first_b, out_last_b,
                           out_cksum_ok_b});
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit sel);
        int n;
        n = 0;
        in_data = b;
        if (sel) in_valid_b = 1'b1;
        else     in_valid   = 1'b1;
        #1;
        while (!(sel ? in_ready_b : in_ready) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stuck 0 for byte %0h", b);
        end
        @(negedge clk);
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic send_str(input string s, input bit sel);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h7C) c = 8'h01;
            send_byte(c, sel);
        end
    endtask

    task automatic expect_rec(input string nm, input vec_t v, input bit sel);
        rec_t r;
        int n;
        n = 0;
        #2;
        while ((sel ? qb.size() : qa.size()) == 0 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        if ((sel ? qb.size() : qa.size()) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.record: got none expected one", nm);
            return;
        end
        r = sel ? qb.pop_front() : qa.pop_front();
        chk({nm, ".tag"},   256'(r.tag),   256'(v.tag));
        chk({nm, ".value"}, r.val,         v.val);
        chk({nm, ".len"},   256'(r.len),   256'(v.len));
        chk({nm, ".err"},   256'(r.err),   256'(v.err));
        chk({nm, ".first"}, 256'(r.first), 256'(v.first));
        chk({nm, ".last"},  256'(r.last),  256'(v.last));
        chk({nm, ".ok"},    256'(r.ok),    256'(v.ok));
    endtask

    vec_t va[17];
    vec_t vb[3];
    vec_t hv;

    initial begin
        va[0]  = '{"35=D|",      32'd35,    256'h44,             1, 0, 0, 0, 0};
        va[1]  = '{"8=A|",       32'd8,     256'h41,             1, 0, 1, 0, 0};
        va[2]  = '{"10=183|",    32'd10,    256'h313833,         3, 0, 0, 1, 1};
        va[3]  = '{"8=A|",       32'd8,     256'h41,             1, 0, 1, 0, 0};
        va[4]  = '{"10=184|",    32'd10,    256'h313834,         3, 0, 0, 1, 0};
        va[5]  = '{"123456=X|",  32'd12345, 256'h0,              0, 1, 0, 0, 0};
        va[6]  = '{"9=Z|",       32'd9,     256'h5A,             1, 0, 0, 0, 0};
        va[7]  = '{"=5|",        32'd0,     256'h0,              0, 1, 0, 0, 0};
        va[8]  = '{"4A=1|",      32'd4,     256'h0,              0, 1, 0, 0, 0};
        va[9]  = '{"|",          32'd0,     256'h0,              0, 1, 0, 0, 0};
        va[10] = '{"58=|",       32'd58,    256'h0,              0, 0, 0, 0, 0};
        va[11] = '{"8=FIX.4.2|", 32'd8,     256'h4649582E342E32, 7, 0, 1, 0, 0};
        va[12] = '{"9=5|",       32'd9,     256'h35,             1, 0, 0, 0, 0};
        va[13] = '{"10=203|",    32'd10,    256'h323033,         3, 0, 0, 1, 1};
        va[14] = '{"8=A|",       32'd8,     256'h41,             1, 0, 1, 0, 0};
        va[15] = '{"10=18|",     32'd10,    256'h3138,           2, 0, 0, 1, 0};
        va[16] = '{"8X=1|",      32'd8,     256'h0,              0, 1, 0, 0, 0};
        vb[0]  = '{"55=ABCDEF|", 32'd55,    256'h41424344,       4, 1, 0, 0, 0};
        vb[1]  = '{"55=ABCD|",   32'd55,    256'h41424344,       4, 0, 0, 0, 0};
        vb[2]  = '{"7=xy|",      32'd7,     256'h7879,           2, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        #2;
        chk("rst.out_valid", 256'(out_valid), 256'(0));
        chk("rst.in_ready",  256'(in_ready),  256'(1));
        chk("rst.out_tag",   256'(out_tag),   256'(0));
        chk("rst.out_value", out_value,       256'(0));
        chk("rst.out_len",   256'(out_len),   256'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            send_str(va[i].s, 1'b0);
            expect_rec($sformatf("va%0d", i), va[i], 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            send_str(vb[i].s, 1'b1);
            expect_rec($sformatf("vb%0d", i), vb[i], 1'b1);
            @(negedge clk);
        end

        // Reset mid-field drops the partial field
        send_str("77=AB", 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_str("36=C|", 1'b0);
        hv = '{"36=C|", 32'd36, 256'h43, 1, 0, 0, 0, 0};
        expect_rec("midrst", hv, 1'b0);
        @(negedge clk);

        // Backpressure: record held, input stalled, nothing lost
        out_ready = 1'b0;
        send_str("35=D|", 1'b0);
        #2;
        chk("bp.in_ready0",  256'(in_ready),  256'(0));
        chk("bp.out_valid1", 256'(out_valid), 256'(1));
        in_valid = 1'b1;
        in_data  = 8'h34;
        repeat (3) @(negedge clk);
        #2;
        chk("bp.hold_tag",   256'(out_tag),   256'(35));
        chk("bp.hold_value", out_value,       256'h44);
        chk("bp.hold_ready", 256'(in_ready),  256'(0));
        @(negedge clk);
        out_ready = 1'b1;
        send_byte(8'h34, 1'b0);
        send_str("4=E|", 1'b0);
        hv = '{"35=D|", 32'd35, 256'h44, 1, 0, 0, 0, 0};
        expect_rec("bp.first", hv, 1'b0);
        hv = '{"44=E|", 32'd44, 256'h45, 1, 0, 0, 0, 0};
        expect_rec("bp.second", hv, 1'b0);
        @(negedge clk);

        // Consume and new emit in the same cycle
        out_ready = 1'b0;
        send_str("1=A|", 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h01;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("sim.out_valid", 256'(out_valid), 256'(1));
        chk("sim.out_err",   256'(out_err),   256'(1));
        hv = '{"1=A|", 32'd1, 256'h41, 1, 0, 0, 0, 0};
        expect_rec("sim.first", hv, 1'b0);
        hv = '{"|", 32'd0, 256'h0, 0, 1, 0, 0, 0};
        expect_rec("sim.second", hv, 1'b0);

        repeat (4) @(negedge clk);
        chk("extra_a", 256'(qa.size()), 256'(0));
        chk("extra_b", 256'(qb.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
